// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the IF stage.
package fetch_stage_pkg;

    // Reset PC and the bubble instruction (sll $0,$0,0).
    localparam logic [31:0] DefResetPc  = 32'h0000_0000;
    localparam logic [31:0] DefNopInstr = 32'h0000_0000;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StFetch = 2'd1,
        StWait  = 2'd2
    } fetch_state_e;

    // MIPS register field positions within an instruction word.
    localparam int unsigned RsMsb = 25;
    localparam int unsigned RsLsb = 21;
    localparam int unsigned RtMsb = 20;
    localparam int unsigned RtLsb = 16;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid flag with hold and bubble controls.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NopInstr = DefNopInstr
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hold_i,
    input  logic        bubble_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc_plus4_q;
    logic        valid_q;

    // Bubble wins over load; a bubble keeps the previous PC+4.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q    <= NopInstr;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else if (bubble_i) begin
            instr_q <= NopInstr;
            valid_q <= 1'b0;
        end else if (!hold_i) begin
            instr_q    <= instr_i;
            pc_plus4_q <= pc_plus4_i;
            valid_q    <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, next-PC selection, pending redirect capture, fetch FSM and IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] ResetPc  = DefResetPc,
    parameter logic [31:0] NopInstr = DefNopInstr
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        icache_stall_i,
    input  logic [31:0] icache_rdata_i,
    output logic        icache_read_o,
    output logic [29:0] icache_addr_o,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_plus4_o,
    output logic        if_id_valid_o,
    output logic [4:0]  if_id_reg_rs_o,
    output logic [4:0]  if_id_reg_rt_o
);

    fetch_state_e state_q;
    logic         icache_read_q;
    logic [31:0]  pc_q, pc_d;
    logic         pend_valid_q, pend_valid_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  target;
    logic         active;
    logic         hold;
    logic         bubble;

    // Fetch FSM with registered read request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StBoot;
            icache_read_q <= 1'b0;
        end else begin
            case (state_q)
                StBoot: begin
                    state_q       <= StFetch;
                    icache_read_q <= 1'b1;
                end
                StFetch: begin
                    if (icache_stall_i) state_q <= StWait;
                    icache_read_q <= 1'b1;
                end
                StWait: begin
                    if (!icache_stall_i) state_q <= StFetch;
                    icache_read_q <= 1'b1;
                end
                default: begin
                    state_q       <= StBoot;
                    icache_read_q <= 1'b0;
                end
            endcase
        end
    end

    assign active   = (state_q != StBoot);
    assign pc_plus4 = pc_q + 32'd4;

    // Next PC, pending redirect and IF/ID controls, in cache-stall > stall > redirect > fetch order.
    always_comb begin
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        hold         = 1'b1;
        bubble       = 1'b0;
        target       = branch_taken_i ? branch_target_i :
                       jump_i         ? jump_target_i   : pend_pc_q;
        if (active) begin
            if (icache_stall_i) begin
                // ID will not re-present a redirect seen during a cache miss, so remember it.
                if (branch_taken_i || jump_i) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = target;
                end
            end else if (stall_i) begin
                // Hold everything; ID re-presents any redirect once the stall clears.
            end else if (branch_taken_i || jump_i || pend_valid_q) begin
                pc_d         = target & 32'hFFFF_FFFC;
                pend_valid_d = 1'b0;
                bubble       = 1'b1;
            end else begin
                pc_d = pc_plus4;
                hold = 1'b0;
            end
        end
    end

    // PC and pending-redirect state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q         <= ResetPc;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0;
        end else begin
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    if_id_reg #(
        .NopInstr (NopInstr)
    ) u_if_id_reg (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .hold_i     (hold),
        .bubble_i   (bubble),
        .instr_i    (icache_rdata_i),
        .pc_plus4_i (pc_plus4),
        .instr_o    (if_id_instr_o),
        .pc_plus4_o (if_id_pc_plus4_o),
        .valid_o    (if_id_valid_o)
    );

    assign icache_read_o  = icache_read_q;
    assign icache_addr_o  = pc_q[31:2];
    assign if_id_reg_rs_o = if_id_instr_o[RsMsb:RsLsb];
    assign if_id_reg_rt_o = if_id_instr_o[RtMsb:RtLsb];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        icache_stall = 1'b0;
    logic [31:0] icache_rdata = 32'h0;
    logic        icache_read;
    logic [29:0] icache_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [4:0]  if_id_reg_rs;
    logic [4:0]  if_id_reg_rt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit          m_booted;
    logic [31:0] m_pc, m_instr, m_pc4, m_pend_pc;
    bit          m_valid, m_pend;

    fetch_stage u_dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .stall_i          (stall),
        .branch_taken_i   (branch_taken),
        .branch_target_i  (branch_target),
        .jump_i           (jump),
        .jump_target_i    (jump_target),
        .icache_stall_i   (icache_stall),
        .icache_rdata_i   (icache_rdata),
        .icache_read_o    (icache_read),
        .icache_addr_o    (icache_addr),
        .if_id_instr_o    (if_id_instr),
        .if_id_pc_plus4_o (if_id_pc_plus4),
        .if_id_valid_o    (if_id_valid),
        .if_id_reg_rs_o   (if_id_reg_rs),
        .if_id_reg_rt_o   (if_id_reg_rt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Instruction memory contents as a pure function of the byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        if (pc == 32'h0) return 32'h2001_0005;
        return (pc * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    task automatic model_reset();
        m_booted  = 1'b0;
        m_pc      = 32'h0;
        m_instr   = 32'h0;
        m_pc4     = 32'h0;
        m_valid   = 1'b0;
        m_pend    = 1'b0;
        m_pend_pc = 32'h0;
    endtask

    // One clock edge of the IF stage as described behaviourally.
    task automatic model_edge();
        logic [31:0] t;
        if (!m_booted) begin
            m_booted = 1'b1;
        end else if (icache_stall) begin
            if (branch_taken) begin
                m_pend = 1'b1; m_pend_pc = branch_target;
            end else if (jump) begin
                m_pend = 1'b1; m_pend_pc = jump_target;
            end
        end else if (stall) begin
            // nothing moves
        end else if (branch_taken || jump || m_pend) begin
            t       = branch_taken ? branch_target : (jump ? jump_target : m_pend_pc);
            m_pc    = {t[31:2], 2'b00};
            m_instr = 32'h0;
            m_valid = 1'b0;
            m_pend  = 1'b0;
        end else begin
            m_instr = icache_rdata;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all();
        check("pc", {icache_addr, 2'b00}, m_pc);
        check("icache_read", {31'h0, icache_read}, {31'h0, m_booted});
        check("instr", if_id_instr, m_instr);
        check("pc_plus4", if_id_pc_plus4, m_pc4);
        check("valid", {31'h0, if_id_valid}, {31'h0, m_valid});
        check("rs", {27'h0, if_id_reg_rs}, {27'h0, m_instr[25:21]});
        check("rt", {27'h0, if_id_reg_rt}, {27'h0, m_instr[20:16]});
    endtask

    // Drive one cycle of inputs, advance one edge, update model, compare.
    task automatic step(input bit st, input bit ics, input bit br, input logic [31:0] bt,
                        input bit jp, input logic [31:0] jt);
        stall         = st;
        icache_stall  = ics;
        branch_taken  = br;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
        icache_rdata  = ics ? $urandom : mem_word(m_pc);
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Assert reset between edges, check the asynchronous effect, release after an edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_pc", {icache_addr, 2'b00}, 32'h0);
        check("rst_async_valid", {31'h0, if_id_valid}, 32'h0);
        check("rst_async_read", {31'h0, icache_read}, 32'h0);
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();

        // Boot edge, then first fetch.
        idle_step();
        check("boot_read", {31'h0, icache_read}, 32'h1);
        idle_step();
        check("first_instr", if_id_instr, 32'h2001_0005);
        check("first_pc4", if_id_pc_plus4, 32'h4);
        check("first_rt", {27'h0, if_id_reg_rt}, 32'h1);

        // Advance to PC=0x10, stall two cycles, then release.
        repeat (3) idle_step();
        check("at_0x10", {icache_addr, 2'b00}, 32'h10);
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("stall_hold", {icache_addr, 2'b00}, 32'h10);
        idle_step();
        check("stall_release", {icache_addr, 2'b00}, 32'h14);

        // Branch at PC=0x18.
        idle_step();
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        check("branch_pc", {icache_addr, 2'b00}, 32'h40);
        check("branch_bubble", {31'h0, if_id_valid}, 32'h0);
        check("branch_addr", {2'b00, icache_addr}, 32'h10);
        idle_step();

        // Cache miss for 3 cycles with a jump pulse in the first; redirect on the free edge.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80);
        repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("miss_hold", {icache_addr, 2'b00}, 32'h44);
        idle_step();
        check("pend_pc", {icache_addr, 2'b00}, 32'h80);
        check("pend_bubble", {31'h0, if_id_valid}, 32'h0);

        // Branch beats jump; then wrap from the top of the address space.
        step(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200);
        check("br_over_jump", {icache_addr, 2'b00}, 32'h100);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        check("top_pc", {icache_addr, 2'b00}, 32'hFFFF_FFFC);
        idle_step();
        check("wrap_pc", {icache_addr, 2'b00}, 32'h0);
        check("wrap_pc4", if_id_pc_plus4, 32'h0);

        // Reset while waiting on the cache with a redirect pending.
        step(1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
        do_reset();
        idle_step();
        idle_step();
        check("no_stale_redirect", {icache_addr, 2'b00}, 32'h4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 25,
                     $urandom_range(0, 99) < 10, $urandom,
                     $urandom_range(0, 99) < 10, $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
